// File: rtl/analyzer_capture.sv
// Trigger-and-capture stage: records the sample stream into a circular RAM while
// armed, stops a programmable number of samples after a masked pattern match.
module analyzer_capture #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic                  arm,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [ADDR_WIDTH-1:0] post_count,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  armed,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_pos,
  output logic [ADDR_WIDTH:0]   sample_count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] value;
    logic [DATA_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] post;
  } trig_cfg_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  trig_cfg_t             cfg;
  logic [ADDR_WIDTH-1:0] wr_ptr, post_left, t_addr, start;
  logic                  wrap;

  logic                  capturing, we, hit, finish, wrap_nxt;
  logic [ADDR_WIDTH-1:0] wr_nxt, t_fin, start_fin, rd_idx;
  logic [ADDR_WIDTH:0]   count_fin;

  always_comb begin
    capturing = (state == ARMED) || (state == POST);
    // arm wins over a coincident sample, and reset suppresses the RAM write
    we        = capturing && sample_valid && !arm && !reset;
    hit       = ((sample_in ^ cfg.value) & cfg.mask) == '0;
    wr_nxt    = wr_ptr + 1'b1;
    wrap_nxt  = wrap || (&wr_ptr);
    finish    = we && (((state == ARMED) && hit && (cfg.post == '0)) ||
                       ((state == POST) && (post_left == ADDR_WIDTH'(1))));
    t_fin     = (state == ARMED) ? wr_ptr : t_addr;
    start_fin = wrap_nxt ? wr_nxt : '0;
    count_fin = wrap_nxt ? (ADDR_WIDTH+1)'(DEPTH) : {1'b0, wr_nxt};
    rd_idx    = start + rd_addr;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cfg          <= '0;
      wr_ptr       <= '0;
      wrap         <= 1'b0;
      post_left    <= '0;
      t_addr       <= '0;
      start        <= '0;
      armed        <= 1'b0;
      done         <= 1'b0;
      trig_pos     <= '0;
      sample_count <= '0;
      rd_data      <= '0;
    end else begin
      rd_data <= mem[rd_idx];
      if (arm) begin
        state  <= ARMED;
        armed  <= 1'b1;
        done   <= 1'b0;
        wr_ptr <= '0;
        wrap   <= 1'b0;
        cfg    <= '{value: trig_value, mask: trig_mask, post: post_count};
      end else if (we) begin
        wr_ptr <= wr_nxt;
        wrap   <= wrap_nxt;
        if (finish) begin
          // window is registered from the post-write pointer so it is valid with done
          state        <= DONE;
          armed        <= 1'b0;
          done         <= 1'b1;
          start        <= start_fin;
          sample_count <= count_fin;
          trig_pos     <= t_fin - start_fin;
        end else if ((state == ARMED) && hit) begin
          state     <= POST;
          post_left <= cfg.post;
          t_addr    <= wr_ptr;
        end else if (state == POST) begin
          post_left <= post_left - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_analyzer_capture.sv
// Bench for analyzer_capture: directed scenarios plus randomized runs checked
// against a queue-based model of the captured window.
module tb_analyzer_capture;
  logic       clk = 0;
  logic       reset;
  logic [7:0] sample_in, trig_value, trig_mask, post_count, rd_addr, rd_data, trig_pos;
  logic       sample_valid, arm, armed, done;
  logic [8:0] sample_count;

  logic [7:0] s4_in, tv4, tm4, rd4_data;
  logic       s4_valid, s4_arm, armed4, done4;
  logic [3:0] pc4, rd4_addr, trig_pos4;
  logic [4:0] count4;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  analyzer_capture dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .arm(arm), .trig_value(trig_value), .trig_mask(trig_mask), .post_count(post_count),
    .rd_addr(rd_addr), .rd_data(rd_data), .armed(armed), .done(done),
    .trig_pos(trig_pos), .sample_count(sample_count));

  analyzer_capture #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .sample_in(s4_in), .sample_valid(s4_valid),
    .arm(s4_arm), .trig_value(tv4), .trig_mask(tm4), .post_count(pc4),
    .rd_addr(rd4_addr), .rd_data(rd4_data), .armed(armed4), .done(done4),
    .trig_pos(trig_pos4), .sample_count(count4));

  // Reference model: everything captured since arm, then the last DEPTH of it.
  int         m_st;   // 0 idle, 1 armed, 2 post, 3 done
  logic [7:0] hist[$];
  logic [7:0] m_win[$];
  logic [7:0] m_val, m_mask;
  int         m_pc, m_left, m_trig, m_cnt, m_tpos;

  task automatic model_close();
    int n;
    n      = hist.size();
    m_cnt  = (n > 256) ? 256 : n;
    m_tpos = m_trig - (n - m_cnt);
    m_win.delete();
    for (int i = n - m_cnt; i < n; i++) m_win.push_back(hist[i]);
    m_st = 3;
  endtask

  task automatic step(input bit a, input bit v, input logic [7:0] d);
    @(negedge clk);
    arm = a; sample_valid = v; sample_in = d;
    @(posedge clk);
    if (a) begin
      m_st = 1; hist.delete();
      m_val = trig_value; m_mask = trig_mask; m_pc = int'(post_count);
    end else if (v && (m_st == 1 || m_st == 2)) begin
      hist.push_back(d);
      if (m_st == 1) begin
        if (((d ^ m_val) & m_mask) == 8'h00) begin
          m_trig = hist.size() - 1;
          if (m_pc == 0) model_close();
          else begin m_st = 2; m_left = m_pc; end
        end
      end else begin
        m_left--;
        if (m_left == 0) model_close();
      end
    end
    #1;
    arm = 0; sample_valid = 0;
  endtask

  task automatic rd(input int a, output logic [7:0] q);
    rd_addr = a[7:0];
    step(0, 0, 8'h00);
    q = rd_data;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1;
    @(posedge clk); m_st = 0; #1;
    @(posedge clk); #1;
    n_tests += 5;
    if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed got %0b want 0", armed); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    if (trig_pos !== 8'h00) begin n_fail++; $display("FAIL reset_trig_pos got %0d want 0", trig_pos); end
    if (sample_count !== 9'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", sample_count); end
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_basic();
    logic [7:0] q;
    logic [7:0] exp_q[3] = '{8'h00, 8'hA5, 8'hA8};
    int         addr[3]  = '{0, 165, 168};
    trig_value = 8'hA5; trig_mask = 8'hFF; post_count = 8'd3;
    step(1, 0, 8'h00);
    n_tests++;
    if (armed !== 1'b1) begin n_fail++; $display("FAIL basic_armed got %0b want 1", armed); end
    for (int i = 0; i < 400 && m_st != 3; i++) begin
      step(0, 1, 8'(i));
      n_tests++;
      if (done !== (m_st == 3)) begin
        n_fail++; $display("FAIL basic_done_timing sample %h got %0b want %0b", i, done, m_st == 3);
      end
    end
    n_tests += 3;
    if (armed !== 1'b0) begin n_fail++; $display("FAIL basic_armed_end got %0b want 0", armed); end
    if (sample_count !== 9'd169) begin n_fail++; $display("FAIL basic_count got %0d want 169", sample_count); end
    if (trig_pos !== 8'd165) begin n_fail++; $display("FAIL basic_trig_pos got %0d want 165", trig_pos); end
    for (int i = 0; i < 3; i++) begin
      rd(addr[i], q);
      n_tests++;
      if (q !== exp_q[i]) begin n_fail++; $display("FAIL basic_read addr %0d got %h want %h", addr[i], q, exp_q[i]); end
    end
  endtask

  task automatic test_wrap4();
    logic [7:0] exp_q[3] = '{8'h15, 8'h20, 8'h24};
    logic [3:0] addr[3]  = '{4'd0, 4'd11, 4'd15};
    tv4 = 8'h20; tm4 = 8'hFF; pc4 = 4'd4;
    @(negedge clk); s4_arm = 1;
    @(negedge clk); s4_arm = 0; s4_valid = 1;
    for (int i = 0; i <= 8'h24; i++) begin
      s4_in = 8'(i);
      @(negedge clk);
    end
    s4_valid = 0;
    n_tests += 3;
    if (done4 !== 1'b1) begin n_fail++; $display("FAIL wrap4_done got %0b want 1", done4); end
    if (count4 !== 5'd16) begin n_fail++; $display("FAIL wrap4_count got %0d want 16", count4); end
    if (trig_pos4 !== 4'd11) begin n_fail++; $display("FAIL wrap4_trig_pos got %0d want 11", trig_pos4); end
    for (int i = 0; i < 3; i++) begin
      rd4_addr = addr[i];
      @(posedge clk); #1;
      n_tests++;
      if (rd4_data !== exp_q[i]) begin n_fail++; $display("FAIL wrap4_read addr %0d got %h want %h", addr[i], rd4_data, exp_q[i]); end
    end
  endtask

  task automatic test_mask_zero();
    logic [7:0] q;
    trig_value = 8'h77; trig_mask = 8'h00; post_count = 8'd0;
    step(1, 0, 8'h00);
    step(0, 0, 8'h99);
    n_tests += 2;
    if (armed !== 1'b1) begin n_fail++; $display("FAIL mask0_armed got %0b want 1", armed); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL mask0_invalid_done got %0b want 0", done); end
    step(0, 1, 8'h3C);
    n_tests += 4;
    if (done !== 1'b1 || armed !== 1'b0) begin n_fail++; $display("FAIL mask0_done got %0b/%0b want 1/0", done, armed); end
    if (sample_count !== 9'd1) begin n_fail++; $display("FAIL mask0_count got %0d want 1", sample_count); end
    if (trig_pos !== 8'd0) begin n_fail++; $display("FAIL mask0_trig_pos got %0d want 0", trig_pos); end
    rd(0, q);
    if (q !== 8'h3C) begin n_fail++; $display("FAIL mask0_read got %h want 3c", q); end
  endtask

  task automatic test_gaps();
    logic [7:0] q;
    bit         v[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
    logic [7:0] d[10] = '{8'h11, 8'h5A, 8'h22, 8'h50, 8'h53, 8'h55, 8'h66, 8'h77, 8'h5F, 8'h88};
    logic [7:0] w[5]  = '{8'h11, 8'h22, 8'h53, 8'h66, 8'h88};
    trig_value = 8'h5A; trig_mask = 8'hF0; post_count = 8'd2;
    step(1, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(0, v[i], d[i]);
      n_tests++;
      if (done !== (i == 9)) begin n_fail++; $display("FAIL gaps_done step %0d got %0b want %0b", i, done, i == 9); end
    end
    n_tests += 2;
    if (sample_count !== 9'd5) begin n_fail++; $display("FAIL gaps_count got %0d want 5", sample_count); end
    if (trig_pos !== 8'd2) begin n_fail++; $display("FAIL gaps_trig_pos got %0d want 2", trig_pos); end
    for (int i = 0; i < 5; i++) begin
      rd(i, q);
      n_tests++;
      if (q !== w[i]) begin n_fail++; $display("FAIL gaps_read addr %0d got %h want %h", i, q, w[i]); end
    end
  endtask

  task automatic test_reset_post();
    trig_value = 8'hA5; trig_mask = 8'hFF; post_count = 8'd3;
    step(1, 0, 8'h00);
    for (int i = 0; i <= 8'hA6; i++) step(0, 1, 8'(i));
    @(negedge clk); reset = 1;
    @(posedge clk); m_st = 0; #1;
    n_tests += 3;
    if (armed !== 1'b0) begin n_fail++; $display("FAIL rstpost_armed got %0b want 0", armed); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL rstpost_done got %0b want 0", done); end
    if (sample_count !== 9'd0) begin n_fail++; $display("FAIL rstpost_count got %0d want 0", sample_count); end
    @(negedge clk); reset = 0;
    test_basic();
  endtask

  task automatic test_rearm();
    logic [7:0] q;
    logic [7:0] seq[6] = '{8'h40, 8'h41, 8'h42, 8'hF0, 8'h43, 8'h44};
    trig_value = 8'hF0; trig_mask = 8'hFF; post_count = 8'd2;
    step(1, 0, 8'h00);
    for (int i = 0; i < 10; i++) step(0, 1, 8'h10 + 8'(i));
    step(1, 1, 8'hEE);
    foreach (seq[i]) step(0, 1, seq[i]);
    n_tests += 4;
    if (done !== 1'b1) begin n_fail++; $display("FAIL rearm_done got %0b want 1", done); end
    if (sample_count !== 9'd6) begin n_fail++; $display("FAIL rearm_count got %0d want 6", sample_count); end
    if (trig_pos !== 8'd3) begin n_fail++; $display("FAIL rearm_trig_pos got %0d want 3", trig_pos); end
    rd(0, q);
    if (q !== 8'h40) begin n_fail++; $display("FAIL rearm_read0 got %h want 40", q); end
  endtask

  task automatic test_random();
    logic [7:0] q;
    int         a;
    for (int it = 0; it < 15; it++) begin
      trig_value = 8'($urandom); trig_mask = 8'($urandom);
      post_count = 8'($urandom_range(0, 255));
      step(1, 0, 8'h00);
      for (int c = 0; c < 3000 && m_st != 3; c++) begin
        step(0, $urandom_range(0, 3) != 0,
             ($urandom_range(0, 63) == 0) ? trig_value : 8'($urandom));
        n_tests++;
        if (done !== (m_st == 3)) begin n_fail++; $display("FAIL rand_done iter %0d cycle %0d got %0b want %0b", it, c, done, m_st == 3); end
      end
      n_tests++;
      if (m_st != 3) begin
        n_fail++; $display("FAIL rand_timeout iter %0d no trigger within budget", it);
        continue;
      end
      n_tests += 2;
      if (sample_count !== 9'(m_cnt)) begin n_fail++; $display("FAIL rand_count iter %0d got %0d want %0d", it, sample_count, m_cnt); end
      if (trig_pos !== 8'(m_tpos)) begin n_fail++; $display("FAIL rand_trig_pos iter %0d got %0d want %0d", it, trig_pos, m_tpos); end
      for (int k = 0; k < 6; k++) begin
        a = (k == 0) ? m_tpos : $urandom_range(0, m_cnt - 1);
        rd(a, q);
        n_tests++;
        if (q !== m_win[a]) begin n_fail++; $display("FAIL rand_read iter %0d addr %0d got %h want %h", it, a, q, m_win[a]); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; arm = 0; sample_valid = 0; sample_in = 0;
    trig_value = 0; trig_mask = 0; post_count = 0; rd_addr = 0;
    s4_in = 0; s4_valid = 0; s4_arm = 0; tv4 = 0; tm4 = 0; pc4 = 0; rd4_addr = 0;
    m_st = 0;
    test_reset();
    test_basic();
    test_wrap4();
    test_mask_zero();
    test_gaps();
    test_reset_post();
    test_rearm();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
